// File: rtl/ct_split_pkg.sv
// Shared definitions for the ct_split packet router: route-state encoding and
// the bit-width helper used to size the destination field.
package ct_split_pkg;

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } route_state_e;

    // Number of bits needed to represent value (0 for value == 0).
    function automatic int unsigned CLogB2(input int unsigned value);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((value >> i) != 0) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ct_split_if.sv
// Flit bus of the ct_split router: one upstream valid/ready stream and NO
// downstream valid/ready streams, plus the drop indication.
interface ct_split_if #(
    parameter int NO    = 2,
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]    i_data;
    logic                i_valid;
    logic                o_ready;
    logic [NO*WIDTH-1:0] o_data;
    logic [NO-1:0]       o_valid;
    logic [NO-1:0]       i_ready;
    logic                o_drop;

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_drop
    );

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_drop
    );
endinterface

// File: rtl/ct_split_stage.sv
// One-entry output staging register: load wins over drain, so a load and a
// drain in the same cycle leave the entry valid with the new flit.
module ct_split_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/ct_split.sv
// Packet-aware 1-to-NO flit router: the head flit's destination field selects
// an output, held through EOP; out-of-range packets are discarded.
module ct_split
    import ct_split_pkg::*;
#(
    parameter int NO       = 2,
    parameter int WIDTH    = 1,
    parameter int EOP_LOC  = 0,
    parameter int DEST_LOC = 1
) (
    input  logic     clk,
    input  logic     reset,
    ct_split_if.slave bus
);
    localparam int unsigned        NOBITS = CLogB2(NO - 1);
    localparam logic [NOBITS:0]    NO_W   = (NOBITS + 1)'(NO);

    route_state_e       r_state, w_state_nxt;
    logic [NOBITS-1:0]  r_route;
    logic [NOBITS-1:0]  w_dest, w_sel;
    logic               w_eop, w_in_range, w_route_ok, w_accept;
    logic [NO-1:0]      w_slot_free, w_load, w_stg_valid;
    logic [WIDTH-1:0]   w_stg_data [NO];

    assign w_dest      = bus.i_data[DEST_LOC +: NOBITS];
    assign w_eop       = bus.i_data[EOP_LOC];
    assign w_in_range  = {1'b0, w_dest} < NO_W;
    assign w_sel       = (r_state == ST_HEAD) ? w_dest : r_route;
    assign w_slot_free = ~w_stg_valid | bus.i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_HEAD;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_route <= '0;
        else if (w_accept && r_state == ST_HEAD && w_in_range && !w_eop)
            r_route <= w_dest;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                ST_HEAD: if (!w_eop) w_state_nxt = w_in_range ? ST_BODY : ST_DROP;
                ST_BODY, ST_DROP: if (w_eop) w_state_nxt = ST_HEAD;
                default: w_state_nxt = ST_HEAD;
            endcase
        end
    end

    // Discarded flits (DROP state or out-of-range head) are always accepted.
    always_comb begin
        w_route_ok  = (r_state == ST_BODY) || (r_state == ST_HEAD && w_in_range);
        bus.o_ready = 1'b1;
        if (w_route_ok) begin
            bus.o_ready = 1'b0;
            for (int unsigned k = 0; k < NO; k++) begin
                if (w_sel == NOBITS'(k)) bus.o_ready = w_slot_free[k];
            end
        end
        w_accept   = bus.i_valid && bus.o_ready;
        bus.o_drop = (r_state == ST_HEAD) && !w_in_range && w_accept;
        w_load     = '0;
        for (int unsigned k = 0; k < NO; k++) begin
            w_load[k] = w_accept && w_route_ok && (w_sel == NOBITS'(k));
        end
    end

    for (genvar g = 0; g < NO; g++) begin : g_stage
        ct_split_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[g]),
            .i_data  (bus.i_data),
            .i_ready (bus.i_ready[g]),
            .o_valid (w_stg_valid[g]),
            .o_data  (w_stg_data[g])
        );
    end

    always_comb begin
        bus.o_data = '0;
        for (int unsigned k = 0; k < NO; k++) begin
            bus.o_data[WIDTH*k +: WIDTH] = w_stg_data[k];
        end
    end

    assign bus.o_valid = w_stg_valid;
endmodule

// File: tb/tb_ct_split.sv
// Scoreboard bench for ct_split: an NO=4 instance for routing/back-pressure
// and an NO=3 instance for out-of-range drops, sharing one stimulus stream.
module tb_ct_split;
    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] tb_data  = '0;
    logic        tb_valid = 1'b0;
    logic [3:0]  tb_ready = '1;
    logic        sel3     = 1'b0;

    always #5 clk = ~clk;

    ct_split_if #(.NO(4), .WIDTH(16)) bus4 ();
    ct_split_if #(.NO(3), .WIDTH(16)) bus3 ();

    assign bus4.i_data  = tb_data;
    assign bus4.i_valid = tb_valid && !sel3;
    assign bus4.i_ready = tb_ready;
    assign bus3.i_data  = tb_data;
    assign bus3.i_valid = tb_valid && sel3;
    assign bus3.i_ready = tb_ready[2:0];

    ct_split #(.NO(4), .WIDTH(16), .EOP_LOC(0), .DEST_LOC(1)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));
    ct_split #(.NO(3), .WIDTH(16), .EOP_LOC(0), .DEST_LOC(1)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    int          checks = 0;
    int          errors = 0;
    int          no_cur = 4;
    int          m_st = 0;     // 0 head, 1 body, 2 drop
    int          m_route = 0;
    int          drops = 0;
    int          drained [4];
    logic [15:0] q [4][$];
    bit          last_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit mfree(input int k);
        return (q[k].size() == 0) || tb_ready[k];
    endfunction

    task automatic reset_model();
        m_st = 0;
        m_route = 0;
        drops = 0;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            drained[k] = 0;
        end
    endtask

    task automatic clear_counts();
        drops = 0;
        for (int k = 0; k < 4; k++) drained[k] = 0;
    endtask

    // Compare settled outputs against the model, then apply this cycle's drains and accept.
    task automatic sample();
        logic [63:0] od;
        logic [3:0]  ov;
        logic        ordy, odrop;
        logic [15:0] exp_d;
        int          dst;
        bit          er, eop;
        if (sel3) begin
            od = 64'(bus3.o_data); ov = 4'(bus3.o_valid);
            ordy = bus3.o_ready;   odrop = bus3.o_drop;
        end else begin
            od = bus4.o_data;      ov = bus4.o_valid;
            ordy = bus4.o_ready;   odrop = bus4.o_drop;
        end
        dst = int'(tb_data[2:1]);
        eop = tb_data[0];
        case (m_st)
            0:       er = (dst >= no_cur) ? 1'b1 : mfree(dst);
            1:       er = mfree(m_route);
            default: er = 1'b1;
        endcase
        check_eq("o_ready", 32'(ordy), 32'(er));
        check_eq("o_drop", 32'(odrop), 32'(m_st == 0 && tb_valid && dst >= no_cur));
        if (odrop) drops++;
        for (int k = 0; k < no_cur; k++) begin
            check_eq($sformatf("o_valid%0d", k), 32'(ov[k]), 32'(q[k].size() != 0));
            if (ov[k] && tb_ready[k]) begin
                if (q[k].size() == 0) begin
                    check_eq($sformatf("spurious%0d", k), 32'd1, 32'd0);
                end else begin
                    exp_d = q[k].pop_front();
                    check_eq($sformatf("o_data%0d", k), 32'(od[16*k +: 16]), 32'(exp_d));
                    drained[k]++;
                end
            end
        end
        last_acc = tb_valid && ordy;
        if (last_acc) begin
            case (m_st)
                0: begin
                    if (dst >= no_cur) begin
                        if (!eop) m_st = 2;
                    end else begin
                        q[dst].push_back(tb_data);
                        if (!eop) begin m_st = 1; m_route = dst; end
                    end
                end
                1: begin
                    q[m_route].push_back(tb_data);
                    if (eop) m_st = 0;
                end
                default: if (eop) m_st = 0;
            endcase
        end
    endtask

    task automatic cyc();
        #1;
        sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        tb_data  = d;
        tb_valid = 1'b1;
        do begin
            cyc();
            n++;
        end while (!last_acc && n < 20);
        check_eq("accept_timeout", 32'(last_acc), 32'd1);
        tb_valid = 1'b0;
    endtask

    task automatic flush(input int n);
        tb_valid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        reset_model();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ovalid4", 32'(bus4.o_valid), 32'd0);
        check_eq("rst_ovalid3", 32'(bus3.o_valid), 32'd0);
        check_eq("rst_drop4", 32'(bus4.o_drop), 32'd0);
        tb_data = 16'h0006;
        #1;
        check_eq("rst_ordy4", 32'(bus4.o_ready), 32'd1);
        check_eq("rst_ordy3", 32'(bus3.o_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // single-flit packets
        send(16'h0005);
        send(16'h0007);
        flush(2);
        check_eq("single_out2", drained[2], 1);
        check_eq("single_out3", drained[3], 1);

        // route lock across a three-flit packet
        clear_counts();
        send(16'h0002);
        send(16'h00A6);
        send(16'h00B1);
        flush(2);
        check_eq("lock_out1", drained[1], 3);
        check_eq("lock_out3", drained[3], 0);

        // back-pressure isolation
        clear_counts();
        tb_ready = 4'b1110;
        send(16'h0001);
        tb_ready = 4'b1100;
        send(16'h0002);
        tb_data  = 16'h0011;
        tb_valid = 1'b1;
        cyc();
        cyc();
        check_eq("bp_stall", 32'(last_acc), 32'd0);
        tb_ready[0] = 1'b1;
        cyc();
        check_eq("bp_iso_drain", drained[0], 1);
        tb_ready[1] = 1'b1;
        cyc();
        check_eq("bp_release", 32'(last_acc), 32'd1);
        send(16'h0021);
        flush(2);
        check_eq("bp_out1", drained[1], 2);
        check_eq("bp_out0", drained[0], 2);

        // load and drain in the same cycle
        clear_counts();
        for (int i = 0; i < 8; i++) send(16'h0001 | (16'(i) << 4));
        flush(2);
        check_eq("stream_out0", drained[0], 8);

        // out-of-range drop on the NO=3 instance
        clear_counts();
        sel3   = 1'b1;
        no_cur = 3;
        send(16'h0006);
        send(16'h0010);
        send(16'h0009);
        send(16'h0001);
        flush(2);
        check_eq("drop_pulses", drops, 1);
        check_eq("drop_next_out0", drained[0], 1);
        check_eq("drop_out1", drained[1] + drained[2], 0);

        // reset in the middle of a stalled packet
        sel3     = 1'b0;
        no_cur   = 4;
        tb_ready = 4'b1011;
        send(16'h0004);
        #1;
        check_eq("pre_rst_valid2", 32'(bus4.o_valid[2]), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_async_ovalid", 32'(bus4.o_valid), 32'd0);
        reset_model();
        @(negedge clk);
        reset    = 1'b0;
        tb_ready = '1;
        send(16'h0003);
        flush(2);
        check_eq("post_rst_out1", drained[1], 1);
        check_eq("post_rst_out2", drained[2], 0);

        check_eq("sb_empty", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
